// File: rtl/mod_updown_counter.sv
// -----------------------------------------------------------------------------
// mod_updown_counter
//   General counting primitive: up / down / bidirectional counter with a
//   runtime modulus, fixed step, wrap or saturate policy, cascade carry and a
//   sticky overflow flag. Chaining stage N carry_out into stage N+1 carry_in
//   builds multi-digit counters.
//
// Parameters
//   NUM_BITS  : counter width
//   DIR       : "up", "down" or "bidir"
//   WRAP_MODE : "wrap" (modulo modulus+1) or "sat" (clamp at boundary)
//   STEP      : increment/decrement per enabled cycle (1..2^NUM_BITS-1)
//
// Ports
//   clk        : clock, rising edge
//   reset_n    : asynchronous active-low reset
//   s          : 00 hold, 10/01 count (direction per DIR), 11 load
//   carry_in   : count enable / cascade carry
//   modulus    : terminal value, legal range 0..modulus
//   dat_in     : parallel load value (clamped to modulus)
//   clr_ovf    : synchronous clear of ovf
//   result     : registered count
//   carry_out  : combinational boundary-crossing indication
//   ovf        : sticky crossing flag
// -----------------------------------------------------------------------------
module mod_updown_counter #(
  parameter int unsigned NUM_BITS  = 8,
  parameter string       DIR       = "bidir",
  parameter string       WRAP_MODE = "wrap",
  parameter int unsigned STEP      = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          s,
  input  logic                carry_in,
  input  logic [NUM_BITS-1:0] modulus,
  input  logic [NUM_BITS-1:0] dat_in,
  input  logic                clr_ovf,
  output logic [NUM_BITS-1:0] result,
  output logic                carry_out,
  output logic                ovf
);

  // One extra bit so result+STEP and modulus+1 never truncate; the down-wrap
  // path needs a further sign bit because result+modulus+1-STEP may go negative.
  localparam int XW = NUM_BITS + 1;
  localparam int SW = NUM_BITS + 2;

  localparam logic [XW-1:0] STEP_X = XW'(STEP);
  localparam bit DIR_UP_ONLY = (DIR == "up");
  localparam bit DIR_DN_ONLY = (DIR == "down");
  localparam bit SAT         = (WRAP_MODE == "sat");

  logic [NUM_BITS-1:0] r_count;
  logic                r_ovf;

  logic                w_cnt_evt;
  logic                w_dir_up;
  logic                w_oor;
  logic [XW-1:0]       w_cur_x;
  logic [XW-1:0]       w_mod_x;
  logic [XW-1:0]       w_sum_x;
  logic                w_cross_up;
  logic                w_cross_dn;
  logic [NUM_BITS-1:0] w_next;
  logic [NUM_BITS-1:0] w_load_val;

  // Next value for an up count event.
  function automatic logic [NUM_BITS-1:0] f_up_next(input logic [XW-1:0] cur,
                                                    input logic [XW-1:0] mod);
    logic [XW-1:0] m1;
    logic [XW-1:0] sum;
    logic [XW-1:0] t;
    m1  = mod + XW'(1);
    sum = cur + STEP_X;
    if (cur > mod) begin
      t = SAT ? mod : '0;
    end else if (sum <= mod) begin
      t = sum;
    end else if (SAT) begin
      t = mod;
    end else begin
      // sum > mod here, so sum - m1 cannot underflow. A step larger than the
      // range needs one more reduction, and anything left over is clamped.
      t = sum - m1;
      if (t > mod) t = t - m1;
      if (t > mod) t = mod;
    end
    return t[NUM_BITS-1:0];
  endfunction

  // Next value for a down count event.
  function automatic logic [NUM_BITS-1:0] f_dn_next(input logic [XW-1:0] cur,
                                                    input logic [XW-1:0] mod);
    logic signed [SW-1:0] m1s;
    logic signed [SW-1:0] t;
    if (cur > mod) begin
      t = $signed({1'b0, mod});
    end else if (cur >= STEP_X) begin
      t = $signed({1'b0, cur}) - $signed({1'b0, STEP_X});
    end else if (SAT) begin
      t = '0;
    end else begin
      // Mirror of the up-wrap reduction: add the range back once more when a
      // large step overshoots below zero, then floor at zero.
      m1s = $signed({1'b0, mod}) + SW'(1);
      t   = $signed({1'b0, cur}) + m1s - $signed({1'b0, STEP_X});
      if (t < 0) t = t + m1s;
      if (t < 0) t = '0;
    end
    return t[NUM_BITS-1:0];
  endfunction

  always_comb begin
    w_cnt_evt  = carry_in & ((s == 2'b10) | (s == 2'b01));
    w_dir_up   = DIR_UP_ONLY ? 1'b1 : (DIR_DN_ONLY ? 1'b0 : (s == 2'b10));
    w_cur_x    = {1'b0, r_count};
    w_mod_x    = {1'b0, modulus};
    w_sum_x    = w_cur_x + STEP_X;
    w_oor      = (r_count > modulus);
    w_cross_up = w_oor | (w_sum_x > w_mod_x);
    w_cross_dn = w_oor | (w_cur_x < STEP_X);
    w_next     = w_dir_up ? f_up_next(w_cur_x, w_mod_x) : f_dn_next(w_cur_x, w_mod_x);
    w_load_val = (dat_in > modulus) ? modulus : dat_in;
    carry_out  = w_cnt_evt & (w_dir_up ? w_cross_up : w_cross_dn);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (s == 2'b11) begin
        r_count <= w_load_val;
      end else if (w_cnt_evt) begin
        r_count <= w_next;
      end
      // A crossing in the same cycle as a clear keeps the flag set.
      if (carry_out) begin
        r_ovf <= 1'b1;
      end else if (clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign result = r_count;
  assign ovf    = r_ovf;

endmodule

// File: tb/tb_mod_updown_counter.sv
module tb_mod_updown_counter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // A: 8-bit up, wrap, step 1
  logic [1:0] a_s;
  logic       a_cin, a_clr, a_co, a_ovf;
  logic [7:0] a_mod, a_din, a_res;
  // B: 8-bit bidir, sat, step 3
  logic [1:0] b_s;
  logic       b_cin, b_clr, b_co, b_ovf;
  logic [7:0] b_mod, b_din, b_res;
  // Cascade: two 4-bit up wrap stages
  logic [1:0] c_s;
  logic       c_cin0, c_clr, c0_co, c0_ovf, c1_co, c1_ovf;
  logic [3:0] c_mod, c_din, c0_res, c1_res;

  mod_updown_counter #(.NUM_BITS(8), .DIR("up"), .WRAP_MODE("wrap"), .STEP(1)) u_a (
    .clk(clk), .reset_n(rst_n), .s(a_s), .carry_in(a_cin), .modulus(a_mod),
    .dat_in(a_din), .clr_ovf(a_clr), .result(a_res), .carry_out(a_co), .ovf(a_ovf));

  mod_updown_counter #(.NUM_BITS(8), .DIR("bidir"), .WRAP_MODE("sat"), .STEP(3)) u_b (
    .clk(clk), .reset_n(rst_n), .s(b_s), .carry_in(b_cin), .modulus(b_mod),
    .dat_in(b_din), .clr_ovf(b_clr), .result(b_res), .carry_out(b_co), .ovf(b_ovf));

  mod_updown_counter #(.NUM_BITS(4), .DIR("up"), .WRAP_MODE("wrap"), .STEP(1)) u_c0 (
    .clk(clk), .reset_n(rst_n), .s(c_s), .carry_in(c_cin0), .modulus(c_mod),
    .dat_in(c_din), .clr_ovf(c_clr), .result(c0_res), .carry_out(c0_co), .ovf(c0_ovf));

  mod_updown_counter #(.NUM_BITS(4), .DIR("up"), .WRAP_MODE("wrap"), .STEP(1)) u_c1 (
    .clk(clk), .reset_n(rst_n), .s(c_s), .carry_in(c0_co), .modulus(c_mod),
    .dat_in(c_din), .clr_ovf(c_clr), .result(c1_res), .carry_out(c1_co), .ovf(c1_ovf));

  task automatic chk(input string tag, input int got, input int exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int t2_res[8] = '{1, 0, 0, 3, 6, 9, 10, 10};
  int t2_co[8]  = '{0, 1, 1, 0, 0, 0, 1, 1};

  initial begin
    a_s = 2'b00; a_cin = 1'b0; a_clr = 1'b0; a_mod = 8'd9;  a_din = 8'd0;
    b_s = 2'b00; b_cin = 1'b0; b_clr = 1'b0; b_mod = 8'd10; b_din = 8'd0;
    c_s = 2'b00; c_cin0 = 1'b0; c_clr = 1'b0; c_mod = 4'd9; c_din = 4'd0;

    // Reset state
    @(negedge clk);
    chk("rst_res", int'(a_res), 0);
    chk("rst_ovf", int'(a_ovf), 0);
    chk("rst_co",  int'(a_co), 0);
    rst_n = 1'b1;

    // Test 1: up wrap modulus 9
    a_s = 2'b10; a_cin = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      chk("t1_co", int'(a_co), ((i - 1) % 10 == 9) ? 1 : 0);
      tick();
      chk("t1_res", int'(a_res), i % 10);
      chk("t1_ovf", int'(a_ovf), (i >= 10) ? 1 : 0);
    end

    // Test 5: set wins over clear, then clear alone
    a_s = 2'b00; a_clr = 1'b1;
    tick();
    chk("t5_preclr", int'(a_ovf), 0);
    a_clr = 1'b0; a_s = 2'b11; a_din = 8'd9;
    tick();
    chk("t5_load", int'(a_res), 9);
    a_s = 2'b10; a_clr = 1'b1;
    #1 chk("t5_co", int'(a_co), 1);
    tick();
    chk("t5_res", int'(a_res), 0);
    chk("t5_setwins", int'(a_ovf), 1);
    a_s = 2'b00;
    tick();
    chk("t5_clr", int'(a_ovf), 0);
    a_clr = 1'b0;

    // Test 3: load clamp and runtime modulus drop
    a_mod = 8'd20; a_s = 2'b11; a_din = 8'd50;
    tick();
    chk("t3_clamp", int'(a_res), 20);
    a_mod = 8'd5; a_s = 2'b10; a_cin = 1'b1;
    #1 chk("t3_co", int'(a_co), 1);
    tick();
    chk("t3_res", int'(a_res), 0);
    chk("t3_ovf", int'(a_ovf), 1);
    a_s = 2'b00; a_mod = 8'd9;

    // Test 2: bidir sat step 3 modulus 10
    b_s = 2'b11; b_din = 8'd4;
    tick();
    chk("t2_load", int'(b_res), 4);
    b_cin = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b_s = (i < 3) ? 2'b01 : 2'b10;
      #1 chk("t2_co", int'(b_co), t2_co[i]);
      tick();
      chk("t2_res", int'(b_res), t2_res[i]);
    end
    b_s = 2'b00; b_cin = 1'b0;

    // Test 4: cascade of two decades
    c_s = 2'b10; c_cin0 = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("t4_mid_hi", int'(c1_res), 1);
    chk("t4_mid_lo", int'(c0_res), 0);
    for (int i = 0; i < 27; i++) tick();
    chk("t4_hi", int'(c1_res), 3);
    chk("t4_lo", int'(c0_res), 7);
    c_cin0 = 1'b0;
    #1 chk("t4_co_hold", int'(c0_co), 0);
    for (int i = 0; i < 5; i++) tick();
    chk("t4_hold_hi", int'(c1_res), 3);
    chk("t4_hold_lo", int'(c0_res), 7);

    // Test 6: async reset mid-count (ovf still set from test 3)
    a_s = 2'b11; a_din = 8'd6;
    tick();
    a_s = 2'b10; a_cin = 1'b1;
    tick();
    chk("t6_pre_res", int'(a_res), 7);
    chk("t6_pre_ovf", int'(a_ovf), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_res", int'(a_res), 0);
    chk("t6_rst_ovf", int'(a_ovf), 0);
    #2 rst_n = 1'b1;
    tick();
    chk("t6_resume", int'(a_res), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
- Parametrised up/down/bidirectional counter with a runtime-programmable modulus, configurable step, and a selectable wrap or saturate policy.
- Adds a cascade carry chain and a sticky overflow flag.
- Used as the general counting primitive: prescalers, address generators, and multi-stage cascaded counters where stage N's carry_out drives stage N+1's carry_in.

Parameters:
NUM_BITS, 8, counter width in bits.
DIR, "bidir", "up", "down" or "bidir"; fixes which count directions s selects.
WRAP_MODE, "wrap", "wrap" returns modulo (modulus+1); "sat" clamps at the boundary.
STEP, 1, count increment/decrement per enabled cycle; legal range 1..2^NUM_BITS-1.

Ports:
clk  in  1  clock, all state updates on rising edge.
reset_n  in  1  asynchronous, active-low reset.
s  in  2  operation: 00 hold, 10 count up (bidir) / count (up,down), 01 count down (bidir) / count (up,down), 11 load.
carry_in  in  1  count enable / cascade carry; counting occurs only when 1.
modulus  in  NUM_BITS  terminal value; legal count range is 0..modulus.
dat_in  in  NUM_BITS  parallel load value.
clr_ovf  in  1  synchronous clear of the ovf flag.
result  out  NUM_BITS  current count (registered).
carry_out  out  1  combinational boundary-crossing indication, for cascading.
ovf  out  1  sticky flag: a boundary crossing has occurred since the last clear.

Behaviour:
- Reset (reset_n=0, asynchronous, any time including mid-count): result=0, ovf=0. carry_out follows its combinational definition, so it is 0 while s=00.
- Count direction:
  - DIR="up": s=10 and s=01 both count up.
  - DIR="down": s=10 and s=01 both count down.
  - DIR="bidir": s=10 counts up, s=01 counts down.
- Count event: s in {10,01} and carry_in=1. With carry_in=0, result holds and carry_out=0.
- Arithmetic is done in NUM_BITS+1 bits; there is no silent truncation.
- Up count:
  - If result+STEP <= modulus: result <= result+STEP.
  - Otherwise it is a crossing. In wrap mode, result <= result+STEP-(modulus+1). In sat mode, result <= modulus.
- Down count:
  - If result >= STEP: result <= result-STEP.
  - Otherwise it is a crossing. In wrap mode, result <= result+(modulus+1)-STEP. In sat mode, result <= 0.
- Out-of-range state (result > modulus, e.g. after modulus is lowered at runtime):
  - Any count event is a crossing.
  - Up: wrap gives 0, sat gives modulus.
  - Down: gives modulus in both modes.
- Wrap results exceeding modulus again (STEP > modulus+1) are reduced by one further subtraction of (modulus+1). The result is then clamped to modulus if still above it.
- modulus=0: result is forced to 0 on every count event, and every count event is a crossing.
- Load (s=11): result <= min(dat_in, modulus). Load ignores carry_in and is never a crossing.
- carry_out = count event AND the crossing condition evaluated on the current result. It is combinational and asserted in the same cycle as the wrapping/saturating edge. Saturated-hold cycles at the boundary still assert carry_out.
- ovf:
  - Set on any rising edge where carry_out=1.
  - Cleared by clr_ovf=1 on a rising edge. If set and clear occur in the same cycle, set wins.
- Priority: reset_n > load > count > hold.
- Single-cycle latency: an operation sampled at edge k is visible on result immediately after edge k.

Test Plan:
1. NUM_BITS=8, DIR="up", wrap, STEP=1, modulus=9: reset, then s=10, carry_in=1 for 12 cycles -> result 1,2,...,9,0,1,2; carry_out=1 only in the cycle with result=9; ovf=1 from that edge.
2. DIR="bidir", sat, STEP=3, modulus=10: load dat_in=4, then s=01 for 3 cycles -> result 1, 0, 0; carry_out=1 in the last two cycles. Then s=10 for 5 cycles -> 3,6,9,10,10.
3. Load clamp and runtime modulus change: modulus=20, load dat_in=50 -> result=20. Set modulus=5, one up count in wrap mode -> result=0, carry_out=1 that cycle.
4. Cascade: two 4-bit instances, modulus=9 each, stage0.carry_out -> stage1.carry_in, stage0 carry_in=1 -> after 37 cycles stage1/stage0 = 3/7. Hold stage0 carry_in=0 for 5 cycles -> no change in either stage.
5. ovf priority and clear: force a crossing with clr_ovf=1 in the same cycle -> ovf=1. Next cycle, clr_ovf=1 with no crossing -> ovf=0.
6. Async reset mid-count: assert reset_n=0 between clock edges while counting at result=7 -> result=0 and ovf=0 immediately, without waiting for clk. Release -> counting resumes from 0 on the next enabled edge.
